pe_host_driver: RTL and testbench

// Clocked initiator that drives one pe_logic tile across its 4-phase bundled-data channels.
// - Host writes filter, ifmap and psum seeds into local buffers.
// - On go: loads the PE caches, sends the start token, feeds psum_in, collects psum_out, then waits for done.
// - All PE-bound traffic goes on one tagged TX channel, which an external demux fans out; psum_out and done come back on RX channels.

---
 rtl/pe_host_driver.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_pe_host_driver.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_host_driver.sv
// Host-side initiator for one pe_logic tile: buffers host data, loads the PE over a tagged
// 4-phase TX channel, then collects psum_out words and the done token over RX channels.
module pe_host_driver #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_I = 5,
    parameter int DEPTH_F = 3,
    parameter int NUM_OUT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hwr_en,
    input  logic [1:0]       hwr_sel,
    input  logic [3:0]       hwr_idx,
    input  logic [WIDTH-1:0] hwr_data,
    input  logic [3:0]       hrd_idx,
    output logic [WIDTH-1:0] hrd_data,
    input  logic             go,
    output logic             busy,
    output logic             done_irq,
    output logic             tx_req,
    input  logic             tx_ack,
    output logic [2:0]       tx_ch,
    output logic [WIDTH-1:0] tx_data,
    input  logic             rx_req,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_ack,
    input  logic             dn_req,
    output logic             dn_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_LDF, S_LDI, S_START, S_PSTX, S_PSRX, S_WAIT_DN, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_RAISE, PH_ACK, PH_REL
    } phase_t;

    state_t           state_q, state_d;
    phase_t           ph_q, ph_d;
    logic [3:0]       idx_q, idx_d;
    logic             sel_q, sel_d;
    logic             tx_req_q, tx_req_d;
    logic [2:0]       tx_ch_q, tx_ch_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             rx_ack_q, rx_ack_d;
    logic             dn_ack_q, dn_ack_d;
    logic             res_we;
    logic             is_tx;

    logic [WIDTH-1:0] filt_q [DEPTH_F];
    logic [WIDTH-1:0] ifm_q  [DEPTH_I];
    logic [WIDTH-1:0] ps_q   [NUM_OUT];
    logic [WIDTH-1:0] res_q  [NUM_OUT];

    logic [1:0]       tx_ack_sq, rx_req_sq, dn_req_sq;
    logic             tx_ack_s, rx_req_s, dn_req_s;
    logic [WIDTH-1:0] f_rd, i_rd, p_rd;
    logic [2:0]       w_ch;
    logic [WIDTH-1:0] w_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ack_sq <= '0;
            rx_req_sq <= '0;
            dn_req_sq <= '0;
        end else begin
            tx_ack_sq <= {tx_ack_sq[0], tx_ack};
            rx_req_sq <= {rx_req_sq[0], rx_req};
            dn_req_sq <= {dn_req_sq[0], dn_req};
        end
    end

    assign tx_ack_s = tx_ack_sq[1];
    assign rx_req_s = rx_req_sq[1];
    assign dn_req_s = dn_req_sq[1];

    always_comb begin
        f_rd = '0;
        i_rd = '0;
        p_rd = '0;
        for (int unsigned j = 0; j < DEPTH_F; j++)
            if (idx_q == 4'(j)) f_rd = filt_q[j];
        for (int unsigned j = 0; j < DEPTH_I; j++)
            if (idx_q == 4'(j)) i_rd = ifm_q[j];
        for (int unsigned j = 0; j < NUM_OUT; j++)
            if (idx_q == 4'(j)) p_rd = ps_q[j];
    end

    always_comb begin
        hrd_data = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++)
            if (hrd_idx == 4'(j)) hrd_data = res_q[j];
    end

    // sel_q picks the address word (0) or data word (1) of each cache load pair
    always_comb begin
        w_ch   = '0;
        w_data = '0;
        case (state_q)
            S_LDF: begin
                w_ch   = sel_q ? 3'd1 : 3'd0;
                w_data = sel_q ? f_rd : WIDTH'(idx_q);
            end
            S_LDI: begin
                w_ch   = sel_q ? 3'd3 : 3'd2;
                w_data = sel_q ? i_rd : WIDTH'(idx_q);
            end
            S_START: begin
                w_ch   = 3'd5;
                w_data = '0;
            end
            S_PSTX: begin
                w_ch   = 3'd4;
                w_data = p_rd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < DEPTH_F; j++) filt_q[j] <= '0;
            for (int unsigned j = 0; j < DEPTH_I; j++) ifm_q[j]  <= '0;
            for (int unsigned j = 0; j < NUM_OUT; j++) ps_q[j]   <= '0;
            for (int unsigned j = 0; j < NUM_OUT; j++) res_q[j]  <= '0;
        end else begin
            if (hwr_en && state_q == S_IDLE) begin
                for (int unsigned j = 0; j < DEPTH_F; j++)
                    if (hwr_sel == 2'd0 && hwr_idx == 4'(j)) filt_q[j] <= hwr_data;
                for (int unsigned j = 0; j < DEPTH_I; j++)
                    if (hwr_sel == 2'd1 && hwr_idx == 4'(j)) ifm_q[j] <= hwr_data;
                for (int unsigned j = 0; j < NUM_OUT; j++)
                    if (hwr_sel == 2'd2 && hwr_idx == 4'(j)) ps_q[j] <= hwr_data;
            end
            if (res_we) begin
                for (int unsigned j = 0; j < NUM_OUT; j++)
                    if (idx_q == 4'(j)) res_q[j] <= rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ph_q      <= PH_SETUP;
            idx_q     <= '0;
            sel_q     <= 1'b0;
            tx_req_q  <= 1'b0;
            tx_ch_q   <= '0;
            tx_data_q <= '0;
            rx_ack_q  <= 1'b0;
            dn_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            tx_req_q  <= tx_req_d;
            tx_ch_q   <= tx_ch_d;
            tx_data_q <= tx_data_d;
            rx_ack_q  <= rx_ack_d;
            dn_ack_q  <= dn_ack_d;
        end
    end

    assign is_tx = (state_q == S_LDF) || (state_q == S_LDI) ||
                   (state_q == S_START) || (state_q == S_PSTX);

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        tx_req_d  = tx_req_q;
        tx_ch_d   = tx_ch_q;
        tx_data_d = tx_data_q;
        rx_ack_d  = 1'b0;
        dn_ack_d  = 1'b0;
        res_we    = 1'b0;

        // A TX word completes in PH_REL once the synced ack has returned low
        if (is_tx) begin
            case (ph_q)
                PH_SETUP: begin
                    tx_ch_d   = w_ch;
                    tx_data_d = w_data;
                    ph_d      = PH_RAISE;
                end
                PH_RAISE: begin
                    tx_req_d = 1'b1;
                    ph_d     = PH_ACK;
                end
                PH_ACK: begin
                    if (tx_ack_s) begin
                        tx_req_d = 1'b0;
                        ph_d     = PH_REL;
                    end
                end
                PH_REL: begin
                    if (!tx_ack_s) begin
                        ph_d = PH_SETUP;
                        case (state_q)
                            S_LDF, S_LDI: begin
                                if (!sel_q) begin
                                    sel_d = 1'b1;
                                end else begin
                                    sel_d = 1'b0;
                                    if (state_q == S_LDF && idx_q == 4'(DEPTH_F - 1)) begin
                                        idx_d   = '0;
                                        state_d = S_LDI;
                                    end else if (state_q == S_LDI && idx_q == 4'(DEPTH_I - 1)) begin
                                        idx_d   = '0;
                                        state_d = S_START;
                                    end else begin
                                        idx_d = idx_q + 4'd1;
                                    end
                                end
                            end
                            S_START: begin
                                idx_d   = '0;
                                state_d = S_PSTX;
                            end
                            default: state_d = S_PSRX;
                        endcase
                    end
                end
                default: ph_d = PH_SETUP;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LDF;
                    ph_d    = PH_SETUP;
                    idx_d   = '0;
                    sel_d   = 1'b0;
                end
            end
            S_PSRX: begin
                rx_ack_d = rx_ack_q;
                if (!rx_ack_q) begin
                    if (rx_req_s) begin
                        res_we   = 1'b1;
                        rx_ack_d = 1'b1;
                    end
                end else if (!rx_req_s) begin
                    rx_ack_d = 1'b0;
                    if (idx_q == 4'(NUM_OUT - 1)) begin
                        idx_d   = '0;
                        state_d = S_WAIT_DN;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_PSTX;
                    end
                end
            end
            S_WAIT_DN: begin
                dn_ack_d = dn_ack_q;
                if (!dn_ack_q) begin
                    if (dn_req_s) dn_ack_d = 1'b1;
                end else if (!dn_req_s) begin
                    dn_ack_d = 1'b0;
                    state_d  = S_FIN;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done_irq = (state_q == S_FIN);
    assign tx_req   = tx_req_q;
    assign tx_ch    = tx_ch_q;
    assign tx_data  = tx_data_q;
    assign rx_ack   = rx_ack_q;
    assign dn_ack   = dn_ack_q;

endmodule

// File: tb/tb_pe_host_driver.sv
// Bench for pe_host_driver: a behavioural pe_logic BFM with random handshake delays answers
// the TX/RX channels; results are checked against convolution sums of the host buffers.
module tb_pe_host_driver;

    localparam int WIDTH   = 8;
    localparam int DEPTH_I = 5;
    localparam int DEPTH_F = 3;
    localparam int NUM_OUT = 3;

    logic             clk;
    logic             rst_n;
    logic             hwr_en;
    logic [1:0]       hwr_sel;
    logic [3:0]       hwr_idx;
    logic [WIDTH-1:0] hwr_data;
    logic [3:0]       hrd_idx;
    logic [WIDTH-1:0] hrd_data;
    logic             go;
    logic             busy;
    logic             done_irq;
    logic             tx_req;
    logic             tx_ack;
    logic [2:0]       tx_ch;
    logic [WIDTH-1:0] tx_data;
    logic             rx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ack;
    logic             dn_req;
    logic             dn_ack;

    pe_host_driver #(.WIDTH(WIDTH), .DEPTH_I(DEPTH_I), .DEPTH_F(DEPTH_F), .NUM_OUT(NUM_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .hwr_en(hwr_en), .hwr_sel(hwr_sel), .hwr_idx(hwr_idx),
        .hwr_data(hwr_data), .hrd_idx(hrd_idx), .hrd_data(hrd_data), .go(go), .busy(busy),
        .done_irq(done_irq), .tx_req(tx_req), .tx_ack(tx_ack), .tx_ch(tx_ch), .tx_data(tx_data),
        .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack), .dn_req(dn_req), .dn_ack(dn_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // control from the main sequence
    int         run_id = 0;
    int         dly_max = 3;
    bit         early_rx = 1'b0;
    logic [7:0] early_val = '0;
    int         viol_seen = 0;

    // host-side shadow of the buffers and expected results
    logic [7:0] sf [DEPTH_F];
    logic [7:0] si [DEPTH_I];
    logic [7:0] sp [NUM_OUT];
    logic [7:0] exp_r [NUM_OUT];

    // BFM state (written only by the BFM process)
    int         seen_run = 0;
    int         viol = 0;
    int         tst, tcnt, rst_s, rcnt, dst, dcnt;
    int         pfa, pia, pc, outs, dn_cnt;
    bit         started, ch2seen, early_done, early_cur;
    logic [2:0] lch;
    logic [7:0] ldat, rval;
    logic [7:0] pf [DEPTH_F];
    logic [7:0] pi [DEPTH_I];
    logic [7:0] pend [$];
    logic [2:0] log_ch [$];
    logic [7:0] log_dat [$];

    task automatic pe_accept(input logic [2:0] ch, input logic [7:0] d);
        int acc;
        case (ch)
            3'd0: pfa = int'(d);
            3'd1: if (pfa < DEPTH_F) pf[pfa] = d;
            3'd2: pia = int'(d);
            3'd3: if (pia < DEPTH_I) pi[pia] = d;
            3'd5: started = (d == 8'd0);
            3'd4: begin
                if (started && pc < NUM_OUT) begin
                    acc = int'(d);
                    for (int j = 0; j < DEPTH_F; j++) acc += int'(pf[j]) * int'(pi[pc + j]);
                    if (!(early_rx && pc == 0)) pend.push_back(acc[7:0]);
                end
                pc++;
            end
            default: ;
        endcase
    endtask

    task automatic stab_check();
        if (tx_ch !== lch || tx_data !== ldat) begin
            viol++;
            $display("protocol violation: tx bundle moved ch %0d->%0d data %0d->%0d", lch, tx_ch, ldat, tx_data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || seen_run != run_id) begin
            seen_run = run_id;
            tx_ack = 1'b0; rx_req = 1'b0; dn_req = 1'b0; rx_data = '0;
            tst = 0; tcnt = 0; rst_s = 0; rcnt = 0; dst = 0; dcnt = 0;
            pfa = 0; pia = 0; pc = 0; outs = 0; dn_cnt = 0;
            started = 1'b0; ch2seen = 1'b0; early_done = 1'b0; early_cur = 1'b0;
            pend.delete(); log_ch.delete(); log_dat.delete();
        end else begin
            case (tst)
                0: if (tx_req === 1'b1) begin
                    lch = tx_ch; ldat = tx_data;
                    log_ch.push_back(tx_ch); log_dat.push_back(tx_data);
                    if (tx_ch == 3'd2) ch2seen = 1'b1;
                    tcnt = int'($urandom_range(dly_max, 0));
                    tst = 1;
                end
                1: begin
                    stab_check();
                    if (tx_req !== 1'b1) begin viol++; $display("protocol violation: tx_req dropped before ack"); end
                    if (tcnt == 0) begin tx_ack = 1'b1; tst = 2; end else tcnt--;
                end
                2: begin
                    stab_check();
                    if (tx_req === 1'b0) begin tcnt = int'($urandom_range(dly_max, 0)); tst = 3; end
                end
                default: begin
                    stab_check();
                    if (tx_req !== 1'b0) begin viol++; $display("protocol violation: tx_req rose while ack high"); end
                    if (tcnt == 0) begin tx_ack = 1'b0; pe_accept(lch, ldat); tst = 0; end else tcnt--;
                end
            endcase

            case (rst_s)
                0: begin
                    if (early_rx && !early_done && ch2seen && outs == 0) begin
                        rval = early_val; rcnt = 0; early_cur = 1'b1; rst_s = 1;
                    end else if (pend.size() > 0) begin
                        rval = pend.pop_front(); rcnt = int'($urandom_range(dly_max, 0)); rst_s = 1;
                    end
                end
                1: if (rcnt == 0) begin rx_data = rval; rx_req = 1'b1; rst_s = 2; end else rcnt--;
                2: if (rx_ack === 1'b1) begin rcnt = int'($urandom_range(dly_max, 0)); rst_s = 3; end
                3: if (rcnt == 0) begin rx_req = 1'b0; rst_s = 4; end else rcnt--;
                default: if (rx_ack === 1'b0) begin
                    outs++;
                    if (early_cur) begin early_done = 1'b1; early_cur = 1'b0; end
                    rst_s = 0;
                end
            endcase

            case (dst)
                0: if (outs == NUM_OUT && dn_cnt == 0) begin dcnt = int'($urandom_range(dly_max, 0)); dst = 1; end
                1: if (dcnt == 0) begin dn_req = 1'b1; dst = 2; end else dcnt--;
                2: if (dn_ack === 1'b1) begin dcnt = int'($urandom_range(dly_max, 0)); dst = 3; end
                3: if (dcnt == 0) begin dn_req = 1'b0; dst = 4; end else dcnt--;
                default: if (dn_ack === 1'b0) begin dn_cnt++; dst = 0; end
            endcase

            // acks may only appear once the matching phase of the run has been reached
            if (rx_ack === 1'b1 && pc <= outs) begin viol++; $display("protocol violation: rx_ack before psum_in"); end
            if (dn_ack === 1'b1 && outs < NUM_OUT) begin viol++; $display("protocol violation: dn_ack before all outputs"); end
        end
    end

    task automatic hw_write(input logic [1:0] sel, input int idx, input logic [7:0] d);
        @(negedge clk);
        hwr_en = 1'b1; hwr_sel = sel; hwr_idx = 4'(idx); hwr_data = d;
        @(negedge clk);
        hwr_en = 1'b0;
    endtask

    task automatic load_buffers();
        for (int j = 0; j < DEPTH_F; j++) hw_write(2'd0, j, sf[j]);
        for (int j = 0; j < DEPTH_I; j++) hw_write(2'd1, j, si[j]);
        for (int j = 0; j < NUM_OUT; j++) hw_write(2'd2, j, sp[j]);
    endtask

    task automatic compute_exp();
        int acc;
        for (int n = 0; n < NUM_OUT; n++) begin
            acc = int'(sp[n]);
            for (int j = 0; j < DEPTH_F; j++) acc += int'(sf[j]) * int'(si[n + j]);
            exp_r[n] = acc[7:0];
        end
    endtask

    task automatic start_run(input string nm);
        @(negedge clk); run_id++;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise got %b want 1", nm, busy); end
    endtask

    task automatic wait_done(input string nm);
        int n;
        int irqs;
        n = 0; irqs = 0;
        while (irqs == 0 && n < 8000) begin
            @(negedge clk); n++;
            if (done_irq === 1'b1) irqs++;
        end
        if (irqs != 0) repeat (10) begin
            @(negedge clk);
            if (done_irq === 1'b1) irqs++;
        end
        checks++;
        if (irqs != 1) begin errors++; $display("FAIL %s done_irq_count got %0d want 1", nm, irqs); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after_fin got %b want 0", nm, busy); end
    endtask

    task automatic check_results(input string nm);
        for (int n = 0; n < NUM_OUT + 2; n++) begin
            @(negedge clk);
            hrd_idx = (n < NUM_OUT) ? 4'(n) : ((n == NUM_OUT) ? 4'(NUM_OUT) : 4'd15);
            #1;
            checks++;
            if (hrd_data !== ((n < NUM_OUT) ? exp_r[n] : 8'd0)) begin
                errors++;
                $display("FAIL %s result[%0d] got %0d want %0d", nm, hrd_idx, hrd_data,
                         (n < NUM_OUT) ? exp_r[n] : 8'd0);
            end
        end
    endtask

    task automatic check_protocol(input string nm);
        checks++;
        if (viol != viol_seen) begin
            errors++;
            $display("FAIL %s protocol_violations got %0d want 0", nm, viol - viol_seen);
        end
        viol_seen = viol;
    endtask

    task automatic check_seq(input string nm);
        logic [2:0] ech [$];
        logic [7:0] edat [$];
        for (int k = 0; k < DEPTH_F; k++) begin
            ech.push_back(3'd0); edat.push_back(8'(k));
            ech.push_back(3'd1); edat.push_back(sf[k]);
        end
        for (int k = 0; k < DEPTH_I; k++) begin
            ech.push_back(3'd2); edat.push_back(8'(k));
            ech.push_back(3'd3); edat.push_back(si[k]);
        end
        ech.push_back(3'd5); edat.push_back(8'd0);
        for (int n = 0; n < NUM_OUT; n++) begin ech.push_back(3'd4); edat.push_back(sp[n]); end
        checks++;
        if (log_ch.size() != ech.size()) begin
            errors++;
            $display("FAIL %s tx_count got %0d want %0d", nm, log_ch.size(), ech.size());
        end else begin
            for (int i = 0; i < ech.size(); i++) begin
                checks++;
                if (log_ch[i] !== ech[i] || log_dat[i] !== edat[i]) begin
                    errors++;
                    $display("FAIL %s tx[%0d] got ch%0d/%0d want ch%0d/%0d", nm, i,
                             log_ch[i], log_dat[i], ech[i], edat[i]);
                end
            end
        end
    endtask

    task automatic set_test1();
        sf = '{8'd1, 8'd2, 8'd3};
        si = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        sp = '{8'd0, 8'd0, 8'd0};
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done_irq, tx_req, rx_ack, dn_ack} !== 5'b0 || tx_ch !== 3'd0 || tx_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy%b irq%b req%b rxa%b dna%b ch%0d data%0d want all 0",
                     busy, done_irq, tx_req, rx_ack, dn_ack, tx_ch, tx_data);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done_irq, tx_req, rx_ack, dn_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle got busy%b irq%b req%b want 0", busy, done_irq, tx_req);
        end
        exp_r = '{8'd0, 8'd0, 8'd0};
        check_results("reset_results");
    endtask

    task automatic test_basic();
        dly_max = 3;
        set_test1();
        load_buffers();
        start_run("basic");
        wait_done("basic");
        exp_r = '{8'd14, 8'd20, 8'd26};
        check_results("basic");
        check_seq("basic");
        check_protocol("basic");
    endtask

    task automatic test_back_to_back();
        int n;
        sp = '{8'd10, 8'd20, 8'd30};
        for (int j = 0; j < NUM_OUT; j++) hw_write(2'd2, j, sp[j]);
        start_run("psum_seed");
        wait_done("psum_seed");
        exp_r = '{8'd24, 8'd40, 8'd56};
        check_results("psum_seed");
        start_run("b2b_first");
        n = 0;
        while (done_irq !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        @(negedge clk); run_id++; go = 1'b1;
        @(negedge clk); go = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy); end
        wait_done("b2b_second");
        check_results("b2b_second");
        check_seq("b2b_second");
        check_protocol("b2b");
    endtask

    task automatic test_tx_sequence();
        dly_max = 20;
        start_run("slow_bfm");
        wait_done("slow_bfm");
        exp_r = '{8'd24, 8'd40, 8'd56};
        check_results("slow_bfm");
        check_seq("slow_bfm");
        check_protocol("slow_bfm");
        dly_max = 3;
    endtask

    task automatic test_busy_ignore();
        int n;
        set_test1();
        for (int j = 0; j < NUM_OUT; j++) hw_write(2'd2, j, sp[j]);
        start_run("busy_ignore");
        hw_write(2'd0, 0, 8'hAA);
        hw_write(2'd1, 2, 8'h55);
        hw_write(2'd2, 1, 8'h77);
        n = 0;
        while (rx_ack !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        checks++;
        if (rx_ack !== 1'b1) begin errors++; $display("FAIL busy_ignore psrx_reach got %b want 1", rx_ack); end
        go = 1'b1;
        @(negedge clk); go = 1'b0;
        wait_done("busy_ignore");
        exp_r = '{8'd14, 8'd20, 8'd26};
        check_results("busy_ignore");
        check_seq("busy_ignore");
        check_protocol("busy_ignore");
    endtask

    task automatic test_reset_midrun();
        int n;
        start_run("midrun");
        n = 0;
        while (!(outs == 1 && pc == 1 && tx_req === 1'b1 && tx_ch === 3'd4) && n < 8000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 8000) begin errors++; $display("FAIL midrun reach_pstx2 got timeout want tx_req on ch4"); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_req !== 1'b0 || busy !== 1'b0 || rx_ack !== 1'b0 || tx_ch !== 3'd0) begin
            errors++;
            $display("FAIL midrun_reset got req%b busy%b rxa%b ch%0d want 0", tx_req, busy, rx_ack, tx_ch);
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            hrd_idx = 4'(j); #1;
            checks++;
            if (hrd_data !== 8'd0) begin errors++; $display("FAIL midrun_reset result[%0d] got %0d want 0", j, hrd_data); end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_test1();
        sf = '{8'd4, 8'd0, 8'd7};
        load_buffers();
        start_run("after_reset");
        wait_done("after_reset");
        compute_exp();
        check_results("after_reset");
        check_protocol("after_reset");
    endtask

    task automatic test_early_rx();
        int n;
        bit ack_early;
        set_test1();
        load_buffers();
        early_val = 8'($urandom_range(255, 0));
        early_rx = 1'b1;
        start_run("early_rx");
        n = 0;
        while (rx_req !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        ack_early = 1'b0;
        n = 0;
        while (pc == 0 && n < 8000) begin
            if (rx_ack !== 1'b0) ack_early = 1'b1;
            @(negedge clk); n++;
        end
        checks++;
        if (ack_early) begin errors++; $display("FAIL early_rx rx_ack_before_psrx got 1 want 0"); end
        wait_done("early_rx");
        early_rx = 1'b0;
        exp_r = '{early_val, 8'd20, 8'd26};
        check_results("early_rx");
        check_protocol("early_rx");
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            dly_max = int'($urandom_range(6, 0));
            for (int j = 0; j < DEPTH_F; j++) sf[j] = 8'($urandom_range(255, 0));
            for (int j = 0; j < DEPTH_I; j++) si[j] = 8'($urandom_range(255, 0));
            for (int j = 0; j < NUM_OUT; j++) sp[j] = 8'($urandom_range(255, 0));
            load_buffers();
            hw_write(2'd0, DEPTH_F + int'($urandom_range(8, 0)), 8'hEE);
            hw_write(2'd1, DEPTH_I + int'($urandom_range(8, 0)), 8'hDD);
            hw_write(2'd3, int'($urandom_range(15, 0)), 8'hCC);
            start_run("random");
            wait_done("random");
            compute_exp();
            check_results("random");
            check_seq("random");
            check_protocol("random");
        end
        dly_max = 3;
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; hwr_en = 1'b0; hwr_sel = '0; hwr_idx = '0;
        hwr_data = '0; hrd_idx = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_tx_sequence();
        test_busy_ignore();
        test_reset_midrun();
        test_early_rx();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
